rv32_dmem_responder: RTL

- Data-memory responder: the slave end of the core's load/store port.
- Accepts one request at a time from `rv32_top`'s data interface over a valid/ready request channel and performs a word-addressed read or byte-masked write into an internal array.
- Returns the result over a valid/ready response channel, after a programmable wait-state delay.
- Used in simulation and FPGA builds as the backing data memory for the core.

---
 rtl/rv32_dmem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the core's load/store port: one request at a time,
// a programmable number of wait states, word array with byte-masked stores.
module rv32_dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_sys_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [31:0]       mem [DEPTH];
  logic [WORD_W-1:0] word_idx_c;
  logic [IDX_W-1:0]  mem_idx_c;
  logic              access_err_c;
  logic              mem_we_c;
  logic [31:0]       rd_word_c;

  // Upper address bits only feed the range check, so out-of-range never aliases.
  assign word_idx_c   = addr_q[ADDR_W-1:2];
  assign mem_idx_c    = word_idx_c[IDX_W-1:0];
  assign access_err_c = (addr_q[1:0] != 2'b00) || (word_idx_c >= WORD_W'(DEPTH));
  assign mem_we_c     = (state_q == S_ACCESS) && we_q && !access_err_c;
  assign rd_word_c    = mem[mem_idx_c];

  // Storage array; deliberately not reset.
  always_ff @(posedge clk_sys_i) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[mem_idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = access_err_c;
        rsp_rdata_d = (!access_err_c && !we_q) ? rd_word_c : 32'h0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered, so it tracks the state being entered.
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
